// File: rtl/regfile_pkg.sv
// Shared register-heap definitions: address/data widths, register codes,
// the write-request record and a one-hot helper used for hazard masks.
package regfile_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int REG_DATA_W = 16;
    localparam int REG_NUM    = 16;

    // General-purpose and special register codes of the heap.
    localparam logic [REG_ADDR_W-1:0] R0      = 4'h0;
    localparam logic [REG_ADDR_W-1:0] R1      = 4'h1;
    localparam logic [REG_ADDR_W-1:0] R2      = 4'h2;
    localparam logic [REG_ADDR_W-1:0] R3      = 4'h3;
    localparam logic [REG_ADDR_W-1:0] R4      = 4'h4;
    localparam logic [REG_ADDR_W-1:0] R5      = 4'h5;
    localparam logic [REG_ADDR_W-1:0] R6      = 4'h6;
    localparam logic [REG_ADDR_W-1:0] R7      = 4'h7;
    localparam logic [REG_ADDR_W-1:0] REG_SP  = 4'h8;
    localparam logic [REG_ADDR_W-1:0] REG_T   = 4'h9;
    localparam logic [REG_ADDR_W-1:0] REG_IH  = 4'hA;
    localparam logic [REG_ADDR_W-1:0] REG_RA  = 4'hB;
    localparam logic [REG_ADDR_W-1:0] REG_EPC = 4'hC;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } regwrite_req_t;

    // One bit per heap register, set at the position of addr.
    function automatic logic [REG_NUM-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
        reg_onehot = {{(REG_NUM-1){1'b0}}, 1'b1} << addr;
    endfunction

endpackage

// File: rtl/regwrite_fifo.sv
// In-order queue of pending side writes (exception/interrupt unit).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (empties the queue)
//   push_i/req_i    enqueue req_i (ignored when full)
//   pop_i           dequeue head (ignored when empty)
//   head_o          current head entry
//   count_o         number of valid entries, 0..DEPTH
//   full_o/empty_o  occupancy flags, decoded from the count register
//   entry_addr_o    destination address stored in each slot
//   entry_valid_o   slot currently holds a queued entry
module regwrite_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 push_i,
    input  regwrite_req_t                        req_i,
    input  logic                                 pop_i,
    output regwrite_req_t                        head_o,
    output logic [CNT_W-1:0]                     count_o,
    output logic                                 full_o,
    output logic                                 empty_o,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]     entry_addr_o,
    output logic [DEPTH-1:0]                     entry_valid_o
);

    regwrite_req_t    mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             do_push_s;
    logic             do_pop_s;
    logic [PTR_W-1:0] offset_s;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == CNT_W'(0));
    assign count_o   = count_q;
    assign head_o    = mem_q[rd_ptr_q];
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;

    // Next occupancy: a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_d = count_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers and count; reset discards every queued entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '{addr: 4'h0, data: 16'h0000};
            end
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= req_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        offset_s      = PTR_W'(0);
        entry_valid_o = '0;
        entry_addr_o  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset_s         = PTR_W'(i) - rd_ptr_q;
            entry_valid_o[i] = (CNT_W'(offset_s) < count_q);
            entry_addr_o[i]  = mem_q[i].addr;
        end
    end

endmodule

// File: rtl/regwrite_arbiter.sv
// Arbiter for the register heap's single write port. Writeback has priority;
// side writes from the exception unit queue in order and are guaranteed to
// drain by a one-cycle pipeline stall once they have lost STARVE_LIMIT times.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   wb_we/addr/data_i    writeback request (ignored while stall_o is high)
//   exc_valid/addr/data_i side-write request, accepted when exc_ready_o
//   exc_ready_o          queue has room (from registered count only)
//   stall_o              hold WB this cycle
//   regwrite/wrreg/wdata_o registered heap write port
//   pend_mask_o          one bit per register targeted by a queued entry
module regwrite_arbiter
    import regfile_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_we_i,
    input  logic [REG_ADDR_W-1:0] wb_addr_i,
    input  logic [REG_DATA_W-1:0] wb_data_i,
    input  logic                  exc_valid_i,
    input  logic [REG_ADDR_W-1:0] exc_addr_i,
    input  logic [REG_DATA_W-1:0] exc_data_i,
    output logic                  exc_ready_o,
    output logic                  stall_o,
    output logic                  regwrite_o,
    output logic [REG_ADDR_W-1:0] wrreg_o,
    output logic [REG_DATA_W-1:0] wdata_o,
    output logic [REG_NUM-1:0]    pend_mask_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SW    = $clog2(STARVE_LIMIT + 1);

    regwrite_req_t                    fifo_head_s;
    logic [CNT_W-1:0]                 fifo_count_s;
    logic                             fifo_full_s;
    logic                             fifo_empty_s;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_addr_s;
    logic [DEPTH-1:0]                 entry_valid_s;
    regwrite_req_t                    push_req_s;

    logic                  push_s;
    logic                  pop_s;
    logic                  wb_win_s;
    logic                  queued_s;
    logic                  stall_s;
    logic [REG_NUM-1:0]    pend_mask_s;

    logic [SW-1:0]         starve_q;
    logic [SW-1:0]         starve_d;
    logic                  regwrite_q;
    logic                  regwrite_d;
    logic [REG_ADDR_W-1:0] wrreg_q;
    logic [REG_ADDR_W-1:0] wrreg_d;
    logic [REG_DATA_W-1:0] wdata_q;
    logic [REG_DATA_W-1:0] wdata_d;

    // Ready depends only on the registered count, so a pop on the same edge
    // never re-opens the queue early; this keeps ready free of input paths.
    assign push_s      = exc_valid_i && !fifo_full_s;
    assign push_req_s  = '{addr: exc_addr_i, data: exc_data_i};
    assign queued_s    = (fifo_count_s != CNT_W'(0));
    assign stall_s     = (starve_q == SW'(STARVE_LIMIT));

    regwrite_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .push_i        (push_s),
        .req_i         (push_req_s),
        .pop_i         (pop_s),
        .head_o        (fifo_head_s),
        .count_o       (fifo_count_s),
        .full_o        (fifo_full_s),
        .empty_o       (fifo_empty_s),
        .entry_addr_o  (entry_addr_s),
        .entry_valid_o (entry_valid_s)
    );

    // Write-port arbitration: WB first unless stalled, then the queue head.
    always_comb begin
        regwrite_d = 1'b0;
        wrreg_d    = wrreg_q;
        wdata_d    = wdata_q;
        wb_win_s   = 1'b0;
        pop_s      = 1'b0;
        if (wb_we_i && !stall_s) begin
            wb_win_s   = 1'b1;
            regwrite_d = 1'b1;
            wrreg_d    = wb_addr_i;
            wdata_d    = wb_data_i;
        end else if (!fifo_empty_s) begin
            pop_s      = 1'b1;
            regwrite_d = 1'b1;
            wrreg_d    = fifo_head_s.addr;
            wdata_d    = fifo_head_s.data;
        end else begin
            regwrite_d = 1'b0;
        end
    end

    // Starvation count of edges the queue head lost to WB. Reaching the
    // limit raises stall_o, which forces a pop and clears the count again.
    always_comb begin
        starve_d = starve_q;
        if (pop_s || !queued_s) begin
            starve_d = SW'(0);
        end else if (wb_win_s && !stall_s) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end
    end

    // Pending-register mask over live queue slots for decode hazard checks.
    always_comb begin
        pend_mask_s = {REG_NUM{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid_s[i]) begin
                pend_mask_s = pend_mask_s | reg_onehot(entry_addr_s[i]);
            end else begin
                pend_mask_s = pend_mask_s;
            end
        end
    end

    // Output write-port registers and starvation counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q   <= SW'(0);
            regwrite_q <= 1'b0;
            wrreg_q    <= 4'h0;
            wdata_q    <= 16'h0000;
        end else begin
            starve_q   <= starve_d;
            regwrite_q <= regwrite_d;
            wrreg_q    <= wrreg_d;
            wdata_q    <= wdata_d;
        end
    end

    assign exc_ready_o = !fifo_full_s;
    assign stall_o     = stall_s;
    assign regwrite_o  = regwrite_q;
    assign wrreg_o     = wrreg_q;
    assign wdata_o     = wdata_q;
    assign pend_mask_o = pend_mask_s;

endmodule

// File: tb/tb_regwrite_arbiter.sv
module tb_regwrite_arbiter;

    logic        clk;
    logic        rst_n;
    logic        wb_we_i;
    logic [3:0]  wb_addr_i;
    logic [15:0] wb_data_i;
    logic        exc_valid_i;
    logic [3:0]  exc_addr_i;
    logic [15:0] exc_data_i;
    logic        exc_ready_o;
    logic        stall_o;
    logic        regwrite_o;
    logic [3:0]  wrreg_o;
    logic [15:0] wdata_o;
    logic [15:0] pend_mask_o;

    int n_vec;
    int n_err;
    logic [19:0] exp_q [$];

    regwrite_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb_we_i     (wb_we_i),
        .wb_addr_i   (wb_addr_i),
        .wb_data_i   (wb_data_i),
        .exc_valid_i (exc_valid_i),
        .exc_addr_i  (exc_addr_i),
        .exc_data_i  (exc_data_i),
        .exc_ready_o (exc_ready_o),
        .stall_o     (stall_o),
        .regwrite_o  (regwrite_o),
        .wrreg_o     (wrreg_o),
        .wdata_o     (wdata_o),
        .pend_mask_o (pend_mask_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_regwrite"}, 32'(regwrite_o), 32'h0);
        chk({tag, "_wrreg"}, 32'(wrreg_o), 32'h0);
        chk({tag, "_wdata"}, 32'(wdata_o), 32'h0);
        chk({tag, "_stall"}, 32'(stall_o), 32'h0);
        chk({tag, "_ready"}, 32'(exc_ready_o), 32'h1);
        chk({tag, "_mask"}, 32'(pend_mask_o), 32'h0);
    endtask

    // Scoreboard monitor: every heap write must match the next expected one.
    task automatic monitor();
        logic [19:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && regwrite_o) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected: got %h:%h expected no write", wrreg_o, wdata_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({wrreg_o, wdata_o} !== e) begin
                        n_err++;
                        $display("FAIL sb_write: got %h:%h expected %h:%h",
                                 wrreg_o, wdata_o, e[19:16], e[15:0]);
                    end
                end
            end
        end
    endtask

    // One cycle of stimulus; x* are the hand-computed values after the edge.
    task automatic row(input string name,
                       input logic wwe, input logic [3:0] wa, input logic [15:0] wd,
                       input logic ev,  input logic [3:0] ea, input logic [15:0] ed,
                       input logic xwe, input logic [3:0] xa, input logic [15:0] xd,
                       input logic xrdy, input logic xstall, input logic [15:0] xmask);
        wb_we_i     = wwe;
        wb_addr_i   = wa;
        wb_data_i   = wd;
        exc_valid_i = ev;
        exc_addr_i  = ea;
        exc_data_i  = ed;
        if (xwe) exp_q.push_back({xa, xd});
        tick();
        chk({name, "_regwrite"}, 32'(regwrite_o), 32'(xwe));
        chk({name, "_ready"}, 32'(exc_ready_o), 32'(xrdy));
        chk({name, "_stall"}, 32'(stall_o), 32'(xstall));
        chk({name, "_mask"}, 32'(pend_mask_o), 32'(xmask));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        wb_we_i = 1'b0; wb_addr_i = 4'h0; wb_data_i = 16'h0;
        exc_valid_i = 1'b0; exc_addr_i = 4'h0; exc_data_i = 16'h0;
        fork
            monitor();
        join_none
        #1;
        chk_reset_vals("rst0");
        for (int c = 0; c < 3; c++) begin
            wb_we_i     = 1'($urandom);
            wb_addr_i   = 4'($urandom);
            wb_data_i   = 16'($urandom);
            exc_valid_i = 1'($urandom);
            exc_addr_i  = 4'($urandom);
            exc_data_i  = 16'($urandom);
            tick();
            chk_reset_vals("rst_hold");
        end
        rst_n = 1'b1;

        // First WB write after reset: R3 = 1234.
        row("wb0", 1'b1, 4'h3, 16'h1234, 1'b0, 4'h0, 16'h0, 1'b1, 4'h3, 16'h1234, 1'b1, 1'b0, 16'h0000);
        row("wb1", 1'b0, 4'h0, 16'h0,    1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0,    1'b1, 1'b0, 16'h0000);

        // Idle side write of EPC.
        row("id0", 1'b0, 4'h0, 16'h0, 1'b1, 4'hC, 16'hBEEF, 1'b0, 4'h0, 16'h0,    1'b1, 1'b0, 16'h1000);
        row("id1", 1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0,    1'b1, 4'hC, 16'hBEEF, 1'b1, 1'b0, 16'h0000);
        row("id2", 1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0,    1'b0, 4'h0, 16'h0,    1'b1, 1'b0, 16'h0000);
        chk("hold_wrreg", 32'(wrreg_o), 32'hC);
        chk("hold_wdata", 32'(wdata_o), 32'hBEEF);

        // Full queue under continuous WB: SP, IH accepted, RA held.
        row("fq0",  1'b1, 4'h1, 16'hA000, 1'b1, 4'h8, 16'h5500, 1'b1, 4'h1, 16'hA000, 1'b1, 1'b0, 16'h0100);
        row("fq1",  1'b1, 4'h1, 16'hA001, 1'b1, 4'hA, 16'h6600, 1'b1, 4'h1, 16'hA001, 1'b0, 1'b0, 16'h0500);
        row("fq2",  1'b1, 4'h1, 16'hA002, 1'b1, 4'hB, 16'h7700, 1'b1, 4'h1, 16'hA002, 1'b0, 1'b0, 16'h0500);
        row("fq3",  1'b1, 4'h1, 16'hA003, 1'b1, 4'hB, 16'h7700, 1'b1, 4'h1, 16'hA003, 1'b0, 1'b0, 16'h0500);
        row("fq4",  1'b1, 4'h1, 16'hA004, 1'b1, 4'hB, 16'h7700, 1'b1, 4'h1, 16'hA004, 1'b0, 1'b1, 16'h0500);
        row("fq5",  1'b1, 4'h1, 16'hA005, 1'b1, 4'hB, 16'h7700, 1'b1, 4'h8, 16'h5500, 1'b1, 1'b0, 16'h0400);
        row("fq6",  1'b1, 4'h1, 16'hA006, 1'b1, 4'hB, 16'h7700, 1'b1, 4'h1, 16'hA006, 1'b0, 1'b0, 16'h0C00);
        row("fq7",  1'b1, 4'h1, 16'hA007, 1'b0, 4'h0, 16'h0,    1'b1, 4'h1, 16'hA007, 1'b0, 1'b0, 16'h0C00);
        row("fq8",  1'b1, 4'h1, 16'hA008, 1'b0, 4'h0, 16'h0,    1'b1, 4'h1, 16'hA008, 1'b0, 1'b0, 16'h0C00);
        row("fq9",  1'b1, 4'h1, 16'hA009, 1'b0, 4'h0, 16'h0,    1'b1, 4'h1, 16'hA009, 1'b0, 1'b1, 16'h0C00);
        row("fq10", 1'b1, 4'h1, 16'hA00A, 1'b0, 4'h0, 16'h0,    1'b1, 4'hA, 16'h6600, 1'b1, 1'b0, 16'h0800);
        row("fq11", 1'b0, 4'h0, 16'h0,    1'b0, 4'h0, 16'h0,    1'b1, 4'hB, 16'h7700, 1'b1, 1'b0, 16'h0000);
        row("fq12", 1'b0, 4'h0, 16'h0,    1'b0, 4'h0, 16'h0,    1'b0, 4'h0, 16'h0,    1'b1, 1'b0, 16'h0000);

        // Starvation with a single queued entry: stall on the 5th cycle.
        row("sv0", 1'b1, 4'h2, 16'hB000, 1'b1, 4'hC, 16'h1111, 1'b1, 4'h2, 16'hB000, 1'b1, 1'b0, 16'h1000);
        row("sv1", 1'b1, 4'h2, 16'hB001, 1'b0, 4'h0, 16'h0,    1'b1, 4'h2, 16'hB001, 1'b1, 1'b0, 16'h1000);
        row("sv2", 1'b1, 4'h2, 16'hB002, 1'b0, 4'h0, 16'h0,    1'b1, 4'h2, 16'hB002, 1'b1, 1'b0, 16'h1000);
        row("sv3", 1'b1, 4'h2, 16'hB003, 1'b0, 4'h0, 16'h0,    1'b1, 4'h2, 16'hB003, 1'b1, 1'b0, 16'h1000);
        row("sv4", 1'b1, 4'h2, 16'hB004, 1'b0, 4'h0, 16'h0,    1'b1, 4'h2, 16'hB004, 1'b1, 1'b1, 16'h1000);
        row("sv5", 1'b1, 4'h2, 16'hB005, 1'b0, 4'h0, 16'h0,    1'b1, 4'hC, 16'h1111, 1'b1, 1'b0, 16'h0000);
        row("sv6", 1'b1, 4'h2, 16'hB006, 1'b0, 4'h0, 16'h0,    1'b1, 4'h2, 16'hB006, 1'b1, 1'b0, 16'h0000);
        row("sv7", 1'b0, 4'h0, 16'h0,    1'b0, 4'h0, 16'h0,    1'b0, 4'h0, 16'h0,    1'b1, 1'b0, 16'h0000);

        // Simultaneous push and pop with count 1.
        row("pp0", 1'b0, 4'h0, 16'h0, 1'b1, 4'h5, 16'h0555, 1'b0, 4'h0, 16'h0,    1'b1, 1'b0, 16'h0020);
        row("pp1", 1'b0, 4'h0, 16'h0, 1'b1, 4'h6, 16'h0666, 1'b1, 4'h5, 16'h0555, 1'b1, 1'b0, 16'h0040);
        row("pp2", 1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0,    1'b1, 4'h6, 16'h0666, 1'b1, 1'b0, 16'h0000);
        row("pp3", 1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0,    1'b0, 4'h0, 16'h0,    1'b1, 1'b0, 16'h0000);

        // Async reset with two queued entries; they must never be written.
        row("ar0", 1'b1, 4'h7, 16'hD000, 1'b1, 4'h1, 16'h0AAA, 1'b1, 4'h7, 16'hD000, 1'b1, 1'b0, 16'h0002);
        row("ar1", 1'b1, 4'h7, 16'hD001, 1'b1, 4'h2, 16'h0BBB, 1'b1, 4'h7, 16'hD001, 1'b0, 1'b0, 16'h0006);
        row("ar2", 1'b1, 4'h7, 16'hD002, 1'b0, 4'h0, 16'h0,    1'b1, 4'h7, 16'hD002, 1'b0, 1'b0, 16'h0006);
        @(negedge clk);
        #1;
        wb_we_i = 1'b0;
        exc_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("arst");
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            row("post_rst", 1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b1, 1'b0, 16'h0000);
        end

        chk("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regwrite_arbiter.md
# regwrite_arbiter

Shares the register heap's single write port between the pipeline writeback stage and the exception/interrupt unit, which writes SP, IH, RA and EPC. Writeback has priority. Side writes are held in a small in-order queue. A starvation counter forces a one-cycle pipeline stall so queued side writes always drain. The block sits between the WB stage, the exception unit and the register heap write port, and exports a pending-register mask for decode hazard checks.

## Interface
- DEPTH, 2: side-write queue entries (power of two, ≥2)
- STARVE_LIMIT, 4: consecutive lost arbitration cycles before forcing a stall (≥1)
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset; asynchronous, active-low
- wb_we_i  in  1  writeback write request
- wb_addr_i  in  4  writeback destination register
- wb_data_i  in  16  writeback data
- exc_valid_i  in  1  side-write request
- exc_addr_i  in  4  side-write destination register
- exc_data_i  in  16  side-write data
- exc_ready_o  out  1  queue can accept; a transfer happens when valid&&ready at a rising edge
- stall_o  out  1  pipeline must hold WB this cycle; wb_* is ignored while high
- regwrite_o  out  1  write enable to the heap
- wrreg_o  out  4  write address to the heap
- wdata_o  out  16  write data to the heap
- pend_mask_o  out  16  bit k set while any queued entry targets register k

## Operation
- Queue: FIFO of {addr[3:0], data[15:0]}, DEPTH entries, with a count of 0..DEPTH. Side requests always enqueue; there is no bypass.
- Arbitration at each rising edge:
  - if wb_we_i && !stall_o, the output register takes WB;
  - else if count>0, the output register takes the queue head and pops it;
  - else regwrite_o<=0. wrreg_o and wdata_o hold their last values.
- Push and pop in the same edge: count unchanged, order preserved.
- Full: exc_ready_o = (count<DEPTH). When full, exc_ready_o=0 even if a pop occurs on the same edge. The requester must hold exc_* stable until accepted.
- Starvation counter starve_cnt, 0..STARVE_LIMIT:
  - increments when count>0 and WB wins;
  - clears when a queue entry pops or count==0.
- stall_o = (starve_cnt==STARVE_LIMIT). While stall_o is high the head pops, starve_cnt clears, and stall_o deasserts the next cycle. A stall therefore never exceeds 1 cycle.
- pend_mask_o: OR of one-hot(addr) over valid queue entries. It is combinational from queue state.
- No ordering between WB and side writes is enforced. Decode must stall reads and writes of any register set in pend_mask_o. Two side writes to the same register retire in queue order.
- Reset (RST=0), asynchronous:
  - queue empty, starve_cnt=0;
  - regwrite_o=0, wrreg_o=4'h0, wdata_o=16'h0000;
  - stall_o=0, exc_ready_o=1, pend_mask_o=16'h0000.
- Reset mid-operation discards queued entries. No write is issued for them.

## Timing
- WB latency: a request sampled at edge n gives regwrite_o high during cycle n+1. The heap commits it on that cycle's falling edge.
- Side latency: minimum 2 cycles. The push at edge n pops at edge n+1 if WB is idle, and regwrite_o is high in cycle n+2.
- Worst case under continuous WB: a queued entry issues within STARVE_LIMIT+2 cycles of reaching the head.
- exc_ready_o, stall_o and pend_mask_o change only after rising edges or on reset, with no combinational input-to-output path.
- regwrite_o is high at most one write per cycle and is never X after reset.

## Structure
- Shared package regfile_pkg:
  - REG_ADDR_W=4 and REG_DATA_W=16;
  - register codes R0..R7=4'h0..4'h7, REG_SP=4'h8, REG_T=4'h9, REG_IH=4'hA, REG_RA=4'hB, REG_EPC=4'hC;
  - a packed struct regwrite_req_t {addr, data}.
- One sub-module, regwrite_fifo: synchronous FIFO parameterised by DEPTH, with push/pop/count/full/empty and per-entry address visibility for the mask.
- The top level contains arbitration, the starvation counter and the output registers.

## Test plan
- Reset: hold RST=0 for 3 cycles with random inputs. All outputs keep reset values and exc_ready_o=1. Release; one WB write of R3=16'h1234 gives regwrite_o=1, wrreg_o=3, wdata_o=16'h1234 one cycle later.
- Idle side write: WB idle, push REG_EPC=16'hBEEF. pend_mask_o=16'h1000 one cycle after the push, the heap write appears 2 cycles after the push, and the mask clears on the pop.
- Full queue: push 3 entries back-to-back under continuous WB. exc_ready_o drops after 2 accepts, the third is held, and entries retire in order SP, IH, RA.
- Starvation: continuous WB with 1 queued entry and STARVE_LIMIT=4. stall_o is high exactly 1 cycle, on the 5th cycle after the push. The queued write issues next, and the WB data offered during the stall is not written.
- Simultaneous push and pop: WB idle, count=1, new push on the same edge as the pop. count stays 1 and there is no loss or duplication.
- Async reset with 2 queued entries mid-stream. Outputs clear immediately without waiting for a clock edge, and neither queued entry is ever written.
